fft4_bfly_seq: RTL

- Sequencer for one shared radix-2 DIT butterfly that computes a 4-point forward FFT or inverse FFT.
- Accepts 4 complex samples on a valid/ready stream and stores them in bit-reversed order in an internal 4-entry buffer.
- Issues 4 butterfly operations over 2 stages to the external butterfly, writing results back in place.
- Streams the 4 results out in natural order. Sits between the sample source and the result sink, and owns the butterfly instance's operand and twiddle inputs.

---
 rtl/fft4_pkg.sv | 48 ++++
 rtl/fft4_bfly_seq_if.sv | 28 ++
 rtl/fft4_buf.sv | 69 ++++++
 rtl/fft4_bfly_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fft4_pkg.sv
// Shared types and constants for the 4-point FFT butterfly sequencer:
// FSM states, twiddle constants, bit reversal and the butterfly op table.
package fft4_pkg;

   localparam int W_DEF = 9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_CALC   = 2'd2,
      ST_UNLOAD = 2'd3
   } state_t;

   typedef enum logic {
      TW_W0 = 1'b0,
      TW_W1 = 1'b1
   } tw_sel_t;

   typedef struct packed {
      logic [1:0] a_addr;
      logic [1:0] b_addr;
      tw_sel_t    tw;
   } bfly_op_t;

   // Twiddles as plain integers; the top truncates them to the sample width.
   localparam int TW0_RE     = 1;
   localparam int TW0_IM     = 0;
   localparam int TW1_FWD_RE = 0;
   localparam int TW1_FWD_IM = -1;
   localparam int TW1_INV_RE = 0;
   localparam int TW1_INV_IM = 1;

   function automatic logic [1:0] bitrev2(input logic [1:0] k);
      return {k[0], k[1]};
   endfunction

   function automatic bfly_op_t bfly_op(input logic [1:0] idx);
      bfly_op_t op;
      case (idx)
         2'd0:    op = '{a_addr: 2'd0, b_addr: 2'd1, tw: TW_W0};
         2'd1:    op = '{a_addr: 2'd2, b_addr: 2'd3, tw: TW_W0};
         2'd2:    op = '{a_addr: 2'd0, b_addr: 2'd2, tw: TW_W0};
         default: op = '{a_addr: 2'd1, b_addr: 2'd3, tw: TW_W1};
      endcase
      return op;
   endfunction

endpackage

// File: rtl/fft4_bfly_seq_if.sv
// Sample-in / result-out streams of the FFT sequencer, plus mode and status.
interface fft4_bfly_seq_if
   import fft4_pkg::*;
#(
   parameter int W = W_DEF
);
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_re;
   logic signed [W-1:0] in_im;
   logic                cfg_inv;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_re;
   logic signed [W-1:0] out_im;
   logic                out_last;
   logic                busy;

   modport slave (
      input  in_valid, in_re, in_im, cfg_inv, out_ready,
      output in_ready, out_valid, out_re, out_im, out_last, busy
   );

   modport master (
      output in_valid, in_re, in_im, cfg_inv, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_last, busy
   );
endinterface

// File: rtl/fft4_buf.sv
// 4-entry complex register file: two write ports (butterfly a/b results),
// one operand read pair and one stream read port.
module fft4_buf
   import fft4_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wa_en,
   input  logic [1:0]          wa_addr,
   input  logic signed [W-1:0] wa_re,
   input  logic signed [W-1:0] wa_im,
   input  logic                wb_en,
   input  logic [1:0]          wb_addr,
   input  logic signed [W-1:0] wb_re,
   input  logic signed [W-1:0] wb_im,
   input  logic [1:0]          ra_addr,
   output logic signed [W-1:0] ra_re,
   output logic signed [W-1:0] ra_im,
   input  logic [1:0]          rb_addr,
   output logic signed [W-1:0] rb_re,
   output logic signed [W-1:0] rb_im,
   input  logic [1:0]          rs_addr,
   output logic signed [W-1:0] rs_re,
   output logic signed [W-1:0] rs_im
);
   logic signed [W-1:0] rd_re [4];
   logic signed [W-1:0] rd_im [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_entry
      logic signed [W-1:0] re_q, re_d, im_q, im_d;

      // The op table never targets one address from both ports in a cycle.
      always_comb begin
         re_d = re_q;
         im_d = im_q;
         if (wa_en && (wa_addr == 2'(gi))) begin
            re_d = wa_re;
            im_d = wa_im;
         end
         if (wb_en && (wb_addr == 2'(gi))) begin
            re_d = wb_re;
            im_d = wb_im;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            re_q <= '0;
            im_q <= '0;
         end else begin
            re_q <= re_d;
            im_q <= im_d;
         end
      end

      assign rd_re[gi] = re_q;
      assign rd_im[gi] = im_q;
   end

   assign ra_re = rd_re[ra_addr];
   assign ra_im = rd_im[ra_addr];
   assign rb_re = rd_re[rb_addr];
   assign rb_im = rd_im[rb_addr];
   assign rs_re = rd_re[rs_addr];
   assign rs_im = rd_im[rs_addr];

endmodule

// File: rtl/fft4_bfly_seq.sv
// Sequencer driving one shared radix-2 butterfly through a 4-point (I)FFT.
// Optional macro INV_SCALE_EN: divide inverse-frame outputs by 4 (arith. shift).
module fft4_bfly_seq
   import fft4_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   fft4_bfly_seq_if.slave      io,
   output logic signed [W-1:0] bf_ar,
   output logic signed [W-1:0] bf_ai,
   output logic signed [W-1:0] bf_br,
   output logic signed [W-1:0] bf_bi,
   output logic signed [W-1:0] bf_wr,
   output logic signed [W-1:0] bf_wi,
   input  logic signed [W-1:0] bf_x0r,
   input  logic signed [W-1:0] bf_x0i,
   input  logic signed [W-1:0] bf_x1r,
   input  logic signed [W-1:0] bf_x1i
);
   localparam logic signed [W-1:0] W0_RE  = W'(TW0_RE);
   localparam logic signed [W-1:0] W0_IM  = W'(TW0_IM);
   localparam logic signed [W-1:0] W1F_RE = W'(TW1_FWD_RE);
   localparam logic signed [W-1:0] W1F_IM = W'(TW1_FWD_IM);
   localparam logic signed [W-1:0] W1I_RE = W'(TW1_INV_RE);
   localparam logic signed [W-1:0] W1I_IM = W'(TW1_INV_IM);

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                inv_q, inv_d;
   logic                wa_en, wb_en;
   logic [1:0]          wa_addr, wb_addr, ra_addr, rb_addr;
   logic signed [W-1:0] wa_re, wa_im, wb_re, wb_im;
   logic signed [W-1:0] ra_re, ra_im, rb_re, rb_im, rs_re, rs_im;
   logic signed [W-1:0] out_re_c, out_im_c;
   logic                last_cnt;
   bfly_op_t            op;

   assign last_cnt = (cnt_q == 2'd3);
   assign op       = bfly_op(cnt_q);

   fft4_buf #(.W(W)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wa_en   (wa_en),
      .wa_addr (wa_addr),
      .wa_re   (wa_re),
      .wa_im   (wa_im),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_re   (wb_re),
      .wb_im   (wb_im),
      .ra_addr (ra_addr),
      .ra_re   (ra_re),
      .ra_im   (ra_im),
      .rb_addr (rb_addr),
      .rb_re   (rb_re),
      .rb_im   (rb_im),
      .rs_addr (cnt_q),
      .rs_re   (rs_re),
      .rs_im   (rs_im)
   );

   // cnt_q is the load beat, butterfly op or unload index depending on state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      wa_en   = 1'b0;
      wa_addr = '0;
      wa_re   = '0;
      wa_im   = '0;
      wb_en   = 1'b0;
      wb_addr = '0;
      wb_re   = '0;
      wb_im   = '0;
      ra_addr = '0;
      rb_addr = '0;
      bf_ar   = '0;
      bf_ai   = '0;
      bf_br   = '0;
      bf_bi   = '0;
      bf_wr   = '0;
      bf_wi   = '0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_LOAD;
            cnt_d   = '0;
         end
         ST_LOAD: begin
            if (io.in_valid) begin
               wa_en   = 1'b1;
               wa_addr = bitrev2(cnt_q);
               wa_re   = io.in_re;
               wa_im   = io.in_im;
               if (cnt_q == 2'd0) inv_d = io.cfg_inv;
               cnt_d = cnt_q + 2'd1;
               if (last_cnt) state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            ra_addr = op.a_addr;
            rb_addr = op.b_addr;
            bf_ar   = ra_re;
            bf_ai   = ra_im;
            bf_br   = rb_re;
            bf_bi   = rb_im;
            if (op.tw == TW_W0) begin
               bf_wr = W0_RE;
               bf_wi = W0_IM;
            end else begin
               bf_wr = inv_q ? W1I_RE : W1F_RE;
               bf_wi = inv_q ? W1I_IM : W1F_IM;
            end
            wa_en   = 1'b1;
            wa_addr = op.a_addr;
            wa_re   = bf_x0r;
            wa_im   = bf_x0i;
            wb_en   = 1'b1;
            wb_addr = op.b_addr;
            wb_re   = bf_x1r;
            wb_im   = bf_x1i;
            cnt_d   = cnt_q + 2'd1;
            if (last_cnt) state_d = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            if (io.out_ready) begin
               cnt_d = cnt_q + 2'd1;
               if (last_cnt) state_d = ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_re_c = '0;
      out_im_c = '0;
      if (state_q == ST_UNLOAD) begin
`ifdef INV_SCALE_EN
         out_re_c = inv_q ? (rs_re >>> 2) : rs_re;
         out_im_c = inv_q ? (rs_im >>> 2) : rs_im;
`else
         out_re_c = rs_re;
         out_im_c = rs_im;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inv_q   <= inv_d;
      end
   end

   assign io.in_ready  = (state_q == ST_LOAD);
   assign io.out_valid = (state_q == ST_UNLOAD);
   assign io.busy      = (state_q == ST_CALC) || (state_q == ST_UNLOAD);
   assign io.out_last  = (state_q == ST_UNLOAD) && last_cnt;
   assign io.out_re    = out_re_c;
   assign io.out_im    = out_im_c;

endmodule
